system_sequencer: RTL and testbench
===================================

SYSTEM_SEQUENCER -- requirements
Module: system_sequencer

Interface
REQ-001 Parameter DATA_SIZE, default 5: number of cells held by the downstream system memory.
REQ-002 Parameter GEN_WIDTH, default 8: width of the generation count.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 load_start  input  1  request a serial load of DATA_SIZE bits.
REQ-006 run_start  input  1  request a run of run_gens generations.
REQ-007 run_gens  input  GEN_WIDTH  generation count, sampled with run_start.
REQ-008 dump_start  input  1  request a serial readout of DATA_SIZE bits.
REQ-009 in_bit  input  1  serial load data.
REQ-010 in_valid  input  1  in_bit is valid.
REQ-011 in_ready  output  1  sequencer accepts in_bit this cycle.
REQ-012 out_bit  output  1  serial readout data.
REQ-013 out_valid  output  1  out_bit is valid.
REQ-014 out_ready  input  1  consumer accepts out_bit this cycle.
REQ-015 load_mode, run_mode, output_mode  output  1 each  mode controls to the system memory.
REQ-016 mem_serial_in  output  1  serial data to the system memory.
REQ-017 mem_serial_out  input  1  registered serial output from the system memory.
REQ-018 busy  output  1  high in any state other than IDLE.
REQ-019 done  output  1  one-cycle pulse when an operation completes.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, RUN, DUMP; start inputs SHALL be ignored outside IDLE.
REQ-021 Simultaneous starts in IDLE SHALL have priority run_start > load_start > dump_start; the state SHALL change on the next edge.
REQ-022 In IDLE, all mode outputs, in_ready, out_valid and done SHALL be 0.
REQ-023 In LOAD, in_ready SHALL be 1 and load_mode SHALL equal in_valid, combinationally; mem_serial_in SHALL equal in_bit.
REQ-024 LOAD SHALL count accepted bits (in_valid and in_ready). After the DATA_SIZE-th accepted bit, the FSM SHALL enter IDLE and pulse done in the following cycle.
REQ-025 run_start SHALL latch run_gens. If run_gens is 0, the FSM SHALL stay in IDLE, assert no mode, and pulse done on the next cycle.
REQ-026 In RUN, run_mode SHALL be 1 for exactly run_gens consecutive cycles. The FSM SHALL then enter IDLE and pulse done.
REQ-027 In DUMP, output_mode SHALL be 1 in a cycle only when shifts remain and (out_valid is 0 or out_ready is 1).
REQ-028 In the cycle after each shift, out_valid SHALL be 1 and out_bit SHALL be mem_serial_out; out_bit SHALL hold stable while out_valid is 1 and out_ready is 0.
REQ-029 out_valid SHALL clear when the bit is accepted and no shift occurred in that cycle.
REQ-030 DUMP SHALL issue exactly DATA_SIZE shifts. When the last bit is accepted, the FSM SHALL enter IDLE and pulse done, leaving the memory content rotated back to its original value.
REQ-031 Bit and generation counters SHALL be sized ceil(log2(DATA_SIZE+1)) and GEN_WIDTH respectively and SHALL never wrap.
REQ-032 At most one of load_mode, run_mode, output_mode SHALL be 1 in any cycle.

Reset
REQ-033 Reset SHALL immediately force IDLE, clear all counters, and drive every output to 0, including mid-operation.
REQ-034 Reset SHALL NOT restore a partially loaded or rotated memory; that memory has its own reset.

Structure
REQ-035 The state enum seq_state_t SHALL live in the shared package conway_pkg.
REQ-036 No sub-module is required; the counters SHALL be local registers.

Verification (DATA_SIZE=5, paired with a system_memory_v4 instance)
REQ-037 Load test: load_start, then bits 1,0,0,1,1 with in_valid gaps -> memory reads 5'b10011, done pulses once, busy is 0.
REQ-038 Dump test: with memory at 5'b01101, dump_start and out_ready=1 -> out_bit sequence 0,1,1,0,1, memory ends at 5'b01101, done pulses.
REQ-039 Dump backpressure: out_ready held 0 for 3 cycles mid-dump -> out_bit stays stable, no extra shift, and the full sequence is still correct.
REQ-040 Run test: run_gens=3 -> run_mode is high exactly 3 cycles; run_gens=0 -> done pulses next cycle with no run_mode.
REQ-041 Priority test: load_start, run_start and dump_start in the same cycle -> RUN entered; starts issued while busy are ignored.
REQ-042 Reset test: reset asserted after the 2nd LOAD bit -> all outputs 0 immediately, FSM in IDLE, and a new load completes normally.

Source files
------------

// File: rtl/conway_pkg.sv
// Shared types and helpers for the Conway system sequencer slice.
package conway_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_LOAD = 2'd1,
        SEQ_RUN  = 2'd2,
        SEQ_DUMP = 2'd3
    } seq_state_t;

    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/system_sequencer_if.sv
// Host/memory-side bundle of the system sequencer.
interface system_sequencer_if #(
    parameter int GEN_WIDTH = 8
);
    logic                 load_start;
    logic                 run_start;
    logic [GEN_WIDTH-1:0] run_gens;
    logic                 dump_start;
    logic                 in_bit;
    logic                 in_valid;
    logic                 in_ready;
    logic                 out_bit;
    logic                 out_valid;
    logic                 out_ready;
    logic                 load_mode;
    logic                 run_mode;
    logic                 output_mode;
    logic                 mem_serial_in;
    logic                 mem_serial_out;
    logic                 busy;
    logic                 done;

    modport master (
        output load_start, run_start, run_gens, dump_start,
        output in_bit, in_valid, out_ready, mem_serial_out,
        input  in_ready, out_bit, out_valid,
        input  load_mode, run_mode, output_mode,
        input  mem_serial_in, busy, done
    );

    modport slave (
        input  load_start, run_start, run_gens, dump_start,
        input  in_bit, in_valid, out_ready, mem_serial_out,
        output in_ready, out_bit, out_valid,
        output load_mode, run_mode, output_mode,
        output mem_serial_in, busy, done
    );

endinterface

// File: rtl/system_sequencer.sv
// Sequences serial load, generation runs and serial readout of the
// downstream system memory.
module system_sequencer
    import conway_pkg::*;
#(
    parameter int DATA_SIZE = 5,
    parameter int GEN_WIDTH = 8
) (
    input logic              clk,
    input logic              reset,
    system_sequencer_if.slave bus
);

    localparam int CW = cnt_width(DATA_SIZE);

    localparam logic [1:0] ST_IDLE = SEQ_IDLE;
    localparam logic [1:0] ST_LOAD = SEQ_LOAD;
    localparam logic [1:0] ST_RUN  = SEQ_RUN;
    localparam logic [1:0] ST_DUMP = SEQ_DUMP;

    localparam logic [CW-1:0] LAST = CW'(DATA_SIZE - 1);
    localparam logic [CW-1:0] FULL = CW'(DATA_SIZE);
    localparam logic [GEN_WIDTH-1:0] GEN_ONE = GEN_WIDTH'(1);

    logic [1:0]           state;
    logic [CW-1:0]        bit_cnt;
    logic [GEN_WIDTH-1:0] gen_cnt;
    logic                 done_q;
    logic                 valid_q;

    logic in_idle;
    logic in_load;
    logic in_run;
    logic in_dump;
    logic accept_in;
    logic shift;
    logic accept_out;

    always_comb begin
        in_idle    = (state == ST_IDLE);
        in_load    = (state == ST_LOAD);
        in_run     = (state == ST_RUN);
        in_dump    = (state == ST_DUMP);
        accept_in  = in_load && bus.in_valid;
        // A new shift may only overwrite a bit the consumer has taken.
        shift      = in_dump && (bit_cnt != FULL)
                     && (!valid_q || bus.out_ready);
        accept_out = in_dump && valid_q && bus.out_ready;
    end

    assign bus.in_ready      = in_load;
    assign bus.load_mode     = accept_in;
    assign bus.mem_serial_in = in_load & bus.in_bit;
    assign bus.run_mode      = in_run;
    assign bus.output_mode   = shift;
    assign bus.out_valid     = valid_q;
    assign bus.out_bit       = valid_q & bus.mem_serial_out;
    assign bus.busy          = !in_idle;
    assign bus.done          = done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            gen_cnt <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (1'b1)
                in_idle: begin
                    if (bus.run_start) begin
                        if (bus.run_gens == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state   <= ST_RUN;
                            gen_cnt <= bus.run_gens;
                        end
                    end else if (bus.load_start) begin
                        state   <= ST_LOAD;
                        bit_cnt <= '0;
                    end else if (bus.dump_start) begin
                        state   <= ST_DUMP;
                        bit_cnt <= '0;
                        valid_q <= 1'b0;
                    end
                end
                in_load: begin
                    if (accept_in) begin
                        if (bit_cnt == LAST) begin
                            state   <= ST_IDLE;
                            bit_cnt <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                in_run: begin
                    if (gen_cnt == GEN_ONE) begin
                        state   <= ST_IDLE;
                        gen_cnt <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        gen_cnt <= gen_cnt - 1'b1;
                    end
                end
                in_dump: begin
                    if (shift) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        valid_q <= 1'b1;
                    end else if (accept_out) begin
                        valid_q <= 1'b0;
                        if (bit_cnt == FULL) begin
                            state   <= ST_IDLE;
                            bit_cnt <= '0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_system_sequencer.sv
// Self-checking bench for system_sequencer with a behavioural memory.
module tb_system_sequencer;

    localparam int N = 5;
    localparam int GW = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    system_sequencer_if #(.GEN_WIDTH(GW)) bus ();

    system_sequencer #(
        .DATA_SIZE(N),
        .GEN_WIDTH(GW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Behavioural system memory: shift-in on load, rotate on output.
    logic [N-1:0] mem = '0;
    logic         sout = 1'b0;
    logic         preset_req = 1'b0;
    logic [N-1:0] preset_val = '0;

    always @(posedge clk) begin
        if (preset_req) begin
            mem <= preset_val;
        end else if (bus.load_mode) begin
            mem <= {mem[N-2:0], bus.mem_serial_in};
        end else if (bus.output_mode) begin
            mem  <= {mem[N-2:0], mem[N-1]};
            sout <= mem[N-1];
        end
    end

    assign bus.mem_serial_out = sout;

    int done_cnt = 0;
    always @(negedge clk) if (bus.done) done_cnt++;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [8:0] outs();
        return {bus.busy, bus.done, bus.in_ready, bus.out_valid,
                bus.out_bit, bus.load_mode, bus.run_mode,
                bus.output_mode, bus.mem_serial_in};
    endfunction

    task automatic preset(input logic [N-1:0] v);
        preset_val = v;
        preset_req = 1'b1;
        tick();
        preset_req = 1'b0;
    endtask

    task automatic do_load(input logic [N-1:0] v, input string tag);
        int d0;
        logic bits[$];
        d0 = done_cnt;
        for (int i = N - 1; i >= 0; i--) bits.push_back(v[i]);
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        #1;
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        while (bits.size() > 0) begin
            repeat (1 + $urandom_range(0, 1)) begin
                bus.in_valid = 1'b0;
                #1;
                if (bus.load_mode || !bus.in_ready)
                    check({tag, "_gap"},
                          {30'd0, bus.in_ready, bus.load_mode},
                          32'd2);
                tick();
            end
            bus.in_valid = 1'b1;
            bus.in_bit   = bits.pop_front();
            #1;
            if (!bus.load_mode || bus.mem_serial_in !== bus.in_bit)
                check({tag, "_accept"},
                      {30'd0, bus.load_mode, bus.mem_serial_in},
                      {30'd0, 1'b1, bus.in_bit});
            tick();
        end
        bus.in_valid = 1'b0;
        #1;
        check({tag, "_done"}, {30'd0, bus.done, bus.busy}, 32'd2);
        tick();
        #1;
        check({tag, "_mem"}, {27'd0, mem}, {27'd0, v});
        check({tag, "_done_once"}, done_cnt - d0, 32'd1);
    endtask

    // mode: 0 always ready, 1 three-cycle stall after two bits, 2 random
    task automatic do_dump(input logic [N-1:0] v, input int mode,
                           input string tag);
        logic exp_q[$];
        logic got_q[$];
        int   nsh, hold, cyc, stab_err, mode_err;
        logic stall_prev, prev_bit, seen_done;
        for (int i = N - 1; i >= 0; i--) exp_q.push_back(v[i]);
        nsh = 0; hold = 0; cyc = 0; stab_err = 0; mode_err = 0;
        stall_prev = 1'b0; prev_bit = 1'b0; seen_done = 1'b0;
        bus.dump_start = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        while (cyc < 200) begin
            if (mode == 1 && got_q.size() == 2 && hold < 3) begin
                bus.out_ready = 1'b0;
                hold++;
            end else if (mode == 2) begin
                bus.out_ready = 1'($urandom_range(0, 1));
            end else begin
                bus.out_ready = 1'b1;
            end
            #1;
            if (bus.done) begin
                seen_done = 1'b1;
                break;
            end
            if (stall_prev && bus.out_bit !== prev_bit) stab_err++;
            if (bus.output_mode) nsh++;
            if (int'(bus.output_mode) + int'(bus.run_mode)
                + int'(bus.load_mode) > 1) mode_err++;
            if (bus.out_valid && bus.out_ready)
                got_q.push_back(bus.out_bit);
            stall_prev = bus.out_valid && !bus.out_ready;
            prev_bit   = bus.out_bit;
            cyc++;
            tick();
        end
        bus.out_ready = 1'b0;
        check({tag, "_done"}, {31'd0, seen_done}, 32'd1);
        check({tag, "_nbits"}, got_q.size(), N);
        check({tag, "_seq"}, {31'd0, got_q == exp_q}, 32'd1);
        check({tag, "_shifts"}, nsh, N);
        check({tag, "_stable"}, stab_err, 0);
        check({tag, "_onehot"}, mode_err, 0);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        tick();
        #1;
        check({tag, "_mem"}, {27'd0, mem}, {27'd0, v});
        check({tag, "_done_low"}, {31'd0, bus.done}, 32'd0);
    endtask

    task automatic count_run(input int g, input int already,
                             input string tag);
        int cnt, cyc;
        logic seen_done;
        cnt = already; cyc = 0; seen_done = 1'b0;
        while (cyc < 300) begin
            #1;
            if (bus.done) begin
                seen_done = 1'b1;
                break;
            end
            if (bus.run_mode) cnt++;
            if (bus.load_mode || bus.output_mode || bus.in_ready)
                check({tag, "_excl"}, 32'd1, 32'd0);
            cyc++;
            tick();
        end
        bus.load_start = 1'b0;
        bus.dump_start = 1'b0;
        check({tag, "_done"}, {31'd0, seen_done}, 32'd1);
        check({tag, "_cycles"}, cnt, g);
        tick();
        #1;
        check({tag, "_idle"}, {23'd0, outs()}, 32'd0);
    endtask

    task automatic do_run(input int g, input string tag);
        bus.run_gens  = GW'(g);
        bus.run_start = 1'b1;
        tick();
        bus.run_start = 1'b0;
        if (g == 0) begin
            #1;
            check({tag, "_zero"},
                  {29'd0, bus.done, bus.busy, bus.run_mode}, 32'd4);
            tick();
            #1;
            check({tag, "_zero_after"}, {23'd0, outs()}, 32'd0);
        end else begin
            count_run(g, 0, tag);
        end
    endtask

    initial begin
        logic [N-1:0] v;
        int g;
        bus.load_start = 1'b0;
        bus.run_start  = 1'b0;
        bus.dump_start = 1'b0;
        bus.run_gens   = '0;
        bus.in_bit     = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        repeat (2) tick();
        #1;
        check("reset_outs", {23'd0, outs()}, 32'd0);
        reset = 1'b0;
        tick();

        do_load(5'b10011, "load_dir");
        preset(5'b01101);
        do_dump(5'b01101, 0, "dump_dir");
        do_dump(5'b01101, 1, "dump_bp");

        for (int k = 0; k < 3; k++) begin
            v = N'($urandom);
            do_load(v, "load_rnd");
            do_dump(v, 2, "dump_rnd");
        end

        do_run(3, "run3");
        do_run(0, "run0");
        for (int k = 0; k < 2; k++) begin
            g = int'($urandom_range(1, 12));
            do_run(g, "run_rnd");
        end

        bus.run_gens   = GW'(4);
        bus.load_start = 1'b1;
        bus.run_start  = 1'b1;
        bus.dump_start = 1'b1;
        tick();
        bus.run_start = 1'b0;
        #1;
        check("prio_run", {30'd0, bus.run_mode, bus.in_ready}, 32'd2);
        count_run(4, 0, "prio");

        preset(5'b00000);
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_bit = 1'b1;
        repeat (2) tick();
        bus.in_bit = 1'b0;
        #1;
        check("rst_pre", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_outs", {23'd0, outs()}, 32'd0);
        tick();
        bus.in_valid = 1'b0;
        reset = 1'b0;
        tick();
        v = N'($urandom);
        do_load(v, "load_after_rst");
        do_dump(v, 2, "dump_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
